muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller and datapath for the M-type ALU codes MPY/MPYH/DIV/MODULO (4'b1010..4'b1101).
//  Sits in EX beside the single-cycle ALU and captures operands when a valid M-op arrives.
//  Runs a radix-2 iterative multiply or restoring divide and stalls the pipeline until the result is ready.
// PARAMETERS
//  XLEN      32  operand/result width; even, >=8
//  CNT_W     $clog2(XLEN)+1  iteration counter width (derived, not overridable)
// PORTS
//  clk        in   1     rising-edge clock
//  reset_n    in   1     synchronous active-low reset
//  start      in   1     EX holds an instruction with ALUop==2'b11 this cycle
//  alu_ctrl   in   4     ALU control code; only 1010..1101 are acted on
//  op_a       in   XLEN  rs1 value / dividend / multiplicand
//  op_b       in   XLEN  rs2 value / divisor / multiplier
//  flush      in   1     kill in-flight op (branch/jump redirect)
//  stall      out  1     freeze IF/ID/EX; combinational
//  busy       out  1     state != IDLE (registered)
//  done       out  1     result valid; one-cycle pulse
//  result     out  XLEN  registered result; held until next FIX
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state=IDLE, counter=0, done=0, busy=0, result=0; takes priority over flush and start.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start & alu_ctrl in 1010..1101 -> latch |op_a|, |op_b|, sign flags, op code; counter=XLEN; go CALC.
//     start with any other code is ignored: no stall, stay IDLE.
//   CALC: one shift-add (mul) or shift-subtract (div) step per cycle; counter-- ; at counter==1 go FIX.
//   FIX: apply sign correction, write result; go DONE.
//   DONE: done=1 for exactly this cycle; go IDLE. start in DONE is ignored (same instr still in EX).
//  Latency: start sampled at edge k -> done high in cycle after edge k+XLEN+1 (XLEN+2 cycles total).
//  stall = (state==IDLE & start & valid_code) | state==CALC | state==FIX; deasserted in DONE so EX retires.
//  Arithmetic (all signed, two's complement):
//   MPY  = low XLEN bits of a*b.  MPYH = high XLEN bits of signed 2*XLEN product.
//   DIV  = quotient truncated toward zero.  MODULO = remainder, sign of dividend.
//  Boundaries:
//   divisor==0: DIV -> all ones; MODULO -> op_a. No exception.
//   op_a==-2^(XLEN-1), op_b==-1: DIV -> op_a; MODULO -> 0.
//   |(-2^(XLEN-1))| computed in XLEN+1 bits; no overflow inside the iteration.
//  flush in any state but IDLE -> IDLE at next edge; done not raised; result unchanged.
//  flush and start together in IDLE -> flush wins, op not accepted.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: in IDLE, on divisor==0, the overflow case, or op_a==0 / op_b==0,
//   go straight to FIX with the special result preloaded; done appears 2 cycles after start.
//  Not defined: every op takes the full XLEN+2 cycles; special values come out of the normal FIX step.
// STRUCTURE
//  Shared include muldiv_pkg: M-op code localparams (MD_MPY=4'b1010, MD_MPYH, MD_DIV, MD_MOD) and FSM state encoding.
//   ALU_decoder and this block must use the same code constants.
//  One sub-module, muldiv_step: combinational single-iteration shift-add/shift-subtract.
//  FSM, counter, operand/accumulator registers and sign fix live in muldiv_sequencer.
// TESTING
//  MPY 7 * -3 (code 1010): result 0xFFFFFFEB; done exactly 34 cycles after start; stall high cycles 0..33.
//  MPYH 0x80000000 * 0x80000000: result 0x40000000.
//  DIV -7/2 -> 0xFFFFFFFD; MODULO -7/2 -> 0xFFFFFFFF.
//  DIV 5/0 -> 0xFFFFFFFF; MODULO 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; MODULO -> 0.
//   With MULDIV_EARLY_OUT_EN, done 2 cycles after start.
//  flush at CALC cycle 10: no done; busy=0 next cycle; back-to-back start then accepted with full latency.
//  reset_n low mid-CALC: all outputs 0 next edge. start with code 0100: stall stays 0, busy stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared M-op ALU control codes and the sequencer state encoding.
// ALU_decoder and muldiv_sequencer both import these constants so the two
// always agree on which codes are multi-cycle operations.
package muldiv_pkg;

  localparam logic [3:0] MD_MPY  = 4'b1010;
  localparam logic [3:0] MD_MPYH = 4'b1011;
  localparam logic [3:0] MD_DIV  = 4'b1100;
  localparam logic [3:0] MD_MOD  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // True for the four codes this block acts on.
  function automatic logic is_md_op(input logic [3:0] code);
    return (code >= MD_MPY) && (code <= MD_MOD);
  endfunction

  // True for the codes that run the shift-subtract divider.
  function automatic logic is_div_op(input logic [3:0] code);
    return (code == MD_DIV) || (code == MD_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on unsigned magnitudes.
//   multiply: {acc, mq} holds partial product / remaining multiplier bits;
//             operand is the multiplicand.
//   divide:   acc holds the partial remainder, mq shifts the dividend out at
//             the top and the quotient bits in at the bottom; operand is the
//             divisor. acc is XLEN+1 bits so a shifted remainder never overflows.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] mq,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN:0]   acc_next,
  output logic [XLEN-1:0] mq_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sum      = acc + {1'b0, operand};
    shifted  = {acc[XLEN-1:0], mq[XLEN-1]};
    diff     = {1'b0, shifted} - {2'b00, operand};
    acc_next = acc;
    mq_next  = mq;
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        acc_next = diff[XLEN:0];
        mq_next  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted;
        mq_next  = {mq[XLEN-2:0], 1'b0};
      end
    end else begin
      if (mq[0]) begin
        acc_next = {1'b0, sum[XLEN:1]};
        mq_next  = {sum[0], mq[XLEN-1:1]};
      end else begin
        acc_next = {1'b0, acc[XLEN:1]};
        mq_next  = {acc[0], mq[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MPY/MPYH/DIV/MODULO unit beside the EX ALU.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- zero operands, divide by
// zero and the MIN/-1 division case skip the iteration and finish in 2 cycles.
//
// Handshake: EX presents start with a valid M-op code; the op is accepted at
// the first rising edge where state==IDLE, start is high, the code is an M-op
// and flush is low. stall holds IF/ID/EX frozen from that cycle until FIX;
// done pulses for one cycle in DONE, where stall drops so the instruction
// retires. start seen in DONE is the same instruction and is ignored.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output md_state_e       dbg_state
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] mq;
  logic [XLEN-1:0] opnd;
  logic [3:0]      code;
  logic            neg_q;
  logic            neg_a;
  logic            b_zero;

  logic [XLEN:0]     acc_next;
  logic [XLEN-1:0]   mq_next;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

`ifdef MULDIV_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] special;
  logic            early_hit;
  logic [XLEN-1:0] early_val;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  assign stall     = (state == ST_IDLE && start && is_md_op(alu_ctrl)) ||
                     state == ST_CALC || state == ST_FIX;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Operand magnitudes; -2^(XLEN-1) maps to 2^(XLEN-1), exact as unsigned.
  always_comb begin
    a_mag = op_a[XLEN-1] ? -op_a : op_a;
    b_mag = op_b[XLEN-1] ? -op_b : op_b;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div_op(code)),
    .acc      (acc),
    .mq       (mq),
    .operand  (opnd),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  // Sign correction and result select applied in FIX.
  always_comb begin
    prod_mag = {acc[XLEN-1:0], mq};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -mq : mq;
    rem      = neg_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    case (code)
      MD_MPY:  fix_val = prod[XLEN-1:0];
      MD_MPYH: fix_val = prod[2*XLEN-1:XLEN];
      MD_DIV:  fix_val = b_zero ? '1 : quo;
      default: fix_val = rem;
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (early) fix_val = special;
`endif
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Detect operand patterns whose result is known without iterating.
  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (is_div_op(alu_ctrl)) begin
      if (op_b == '0) begin
        early_hit = 1'b1;
        early_val = (alu_ctrl == MD_DIV) ? '1 : op_a;
      end else if (op_a == XMIN && op_b == '1) begin
        early_hit = 1'b1;
        early_val = (alu_ctrl == MD_DIV) ? op_a : '0;
      end else if (op_a == '0) begin
        early_hit = 1'b1;
      end
    end else if (op_a == '0 || op_b == '0) begin
      early_hit = 1'b1;
    end
  end
`endif

  // Sequencer FSM with operand, accumulator, counter and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mq     <= '0;
      opnd   <= '0;
      code   <= MD_MPY;
      neg_q  <= 1'b0;
      neg_a  <= 1'b0;
      b_zero <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early   <= 1'b0;
      special <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (flush && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !flush && is_md_op(alu_ctrl)) begin
              code   <= alu_ctrl;
              neg_a  <= op_a[XLEN-1];
              neg_q  <= op_a[XLEN-1] ^ op_b[XLEN-1];
              b_zero <= (op_b == '0);
              acc    <= '0;
              cnt    <= CNT_W'(XLEN);
              state  <= ST_CALC;
              if (is_div_op(alu_ctrl)) begin
                mq   <= a_mag;
                opnd <= b_mag;
              end else begin
                mq   <= b_mag;
                opnd <= a_mag;
              end
`ifdef MULDIV_EARLY_OUT_EN
              early   <= early_hit;
              special <= early_val;
              if (early_hit) state <= ST_FIX;
`endif
            end
          end
          ST_CALC: begin
            acc <= acc_next;
            mq  <= mq_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_FIX;
          end
          ST_FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
